// File: rtl/sgd_x_writeback_engine.sv
// Gathers model-update beats from per-engine FIFOs in round-robin engine order and streams
// them to memory as one write command per epoch.
module sgd_x_writeback_engine #(
  parameter int unsigned ENGINE_NUM       = 8,
  parameter int unsigned DATA_W           = 512,
  parameter int unsigned BEATS_PER_ENGINE = 4,
  parameter int unsigned DIMS_PER_ROUND   = 256,
  parameter int unsigned BYTES_PER_DIM    = 4,
  parameter int unsigned RD_LAT           = 1,
  parameter int unsigned OUT_STAGES       = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             started,
  input  logic [63:0]                      addr_model,
  input  logic [31:0]                      dimension,
  input  logic [31:0]                      numEpochs,
  input  logic [ENGINE_NUM-1:0][DATA_W-1:0] x_to_mem_rd_data,
  output logic [ENGINE_NUM-1:0]            x_to_mem_rd_en,
  input  logic [ENGINE_NUM-1:0]            x_to_mem_empty,
  output logic                             x_data_send_back_start,
  output logic [63:0]                      x_data_send_back_addr,
  output logic [31:0]                      x_data_send_back_length,
  output logic [DATA_W-1:0]                x_data_out,
  output logic                             x_data_out_valid,
  input  logic                             x_data_out_almost_full,
  output logic                             done,
  output logic                             error
);

  localparam int unsigned EW = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam int unsigned BW = (BEATS_PER_ENGINE > 1) ? $clog2(BEATS_PER_ENGINE) : 1;
  localparam logic [EW-1:0] EngLast  = EW'(ENGINE_NUM - 1);
  localparam logic [BW-1:0] BeatLast = BW'(BEATS_PER_ENGINE - 1);

  typedef enum logic [1:0] {StIdle, StEpochWait, StData, StDone} state_e;

  state_e        state_q;
  logic          started_q;
  logic          af_q;
  logic [63:0]   base_q;
  logic [31:0]   len_q;
  logic [31:0]   rounds_q;
  logic [31:0]   epochs_q;
  logic [31:0]   epoch_cnt_q;
  logic [31:0]   round_cnt_q;
  logic [EW-1:0] eng_cnt_q;
  logic [BW-1:0] beat_cnt_q;
  logic [EW-1:0] rd_eng_q;

  logic issue;
  logic last_round;

  assign issue      = (state_q == StData) && !af_q && !x_to_mem_empty[eng_cnt_q];
  assign last_round = (round_cnt_q == rounds_q - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                 <= StIdle;
      started_q               <= 1'b0;
      af_q                    <= 1'b0;
      base_q                  <= '0;
      len_q                   <= '0;
      rounds_q                <= '0;
      epochs_q                <= '0;
      epoch_cnt_q             <= '0;
      round_cnt_q             <= '0;
      eng_cnt_q               <= '0;
      beat_cnt_q              <= '0;
      rd_eng_q                <= '0;
      x_to_mem_rd_en          <= '0;
      x_data_send_back_start  <= 1'b0;
      x_data_send_back_addr   <= '0;
      x_data_send_back_length <= '0;
      done                    <= 1'b0;
      error                   <= 1'b0;
    end else begin
      started_q              <= started;
      af_q                   <= x_data_out_almost_full;
      x_to_mem_rd_en         <= '0;
      x_data_send_back_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (started && !started_q) begin
            base_q      <= addr_model;
            len_q       <= dimension * 32'(BYTES_PER_DIM);
            rounds_q    <= 32'((33'(dimension) + 33'(DIMS_PER_ROUND - 1)) / 33'(DIMS_PER_ROUND));
            epochs_q    <= numEpochs;
            epoch_cnt_q <= '0;
            round_cnt_q <= '0;
            eng_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            if (dimension == 32'd0) begin
              error   <= 1'b1;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StEpochWait;
            end
          end
        end
        StEpochWait: begin
          if (epoch_cnt_q == epochs_q) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else if (x_to_mem_empty == '0) begin
            x_data_send_back_start  <= 1'b1;
            x_data_send_back_addr   <= base_q + 64'(epoch_cnt_q) * 64'(len_q);
            x_data_send_back_length <= len_q;
            state_q                 <= StData;
          end
        end
        StData: begin
          if (issue) begin
            x_to_mem_rd_en <= ENGINE_NUM'(1) << eng_cnt_q;
            rd_eng_q       <= eng_cnt_q;
            if (beat_cnt_q == BeatLast) begin
              beat_cnt_q <= '0;
              if (eng_cnt_q == EngLast) begin
                eng_cnt_q <= '0;
                if (last_round) begin
                  round_cnt_q <= '0;
                  epoch_cnt_q <= epoch_cnt_q + 32'd1;
                  state_q     <= StEpochWait;
                end else begin
                  round_cnt_q <= round_cnt_q + 32'd1;
                end
              end else begin
                eng_cnt_q <= eng_cnt_q + EW'(1);
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + BW'(1);
            end
          end
        end
        StDone: begin
          if (!started) begin
            done    <= 1'b0;
            error   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag pipe tracks which engine's read data arrives RD_LAT cycles after rd_en.
  logic [RD_LAT-1:0] tag_vld_q;
  logic [EW-1:0]     tag_eng_q [RD_LAT];
  logic              cap_vld_q;
  logic [DATA_W-1:0] cap_data_q;
  logic [OUT_STAGES-1:0] out_vld_q;
  logic [DATA_W-1:0]     out_data_q [OUT_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_eng_q[i] <= '0;
      cap_vld_q  <= 1'b0;
      cap_data_q <= '0;
      out_vld_q  <= '0;
      for (int i = 0; i < OUT_STAGES; i++) out_data_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= |x_to_mem_rd_en;
      tag_eng_q[0] <= rd_eng_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_eng_q[i] <= tag_eng_q[i-1];
      end
      cap_vld_q <= tag_vld_q[RD_LAT-1];
      if (tag_vld_q[RD_LAT-1]) cap_data_q <= x_to_mem_rd_data[tag_eng_q[RD_LAT-1]];
      out_vld_q[0]  <= cap_vld_q;
      out_data_q[0] <= cap_data_q;
      for (int i = 1; i < OUT_STAGES; i++) begin
        out_vld_q[i]  <= out_vld_q[i-1];
        out_data_q[i] <= out_data_q[i-1];
      end
    end
  end

  assign x_data_out       = out_data_q[OUT_STAGES-1];
  assign x_data_out_valid = out_vld_q[OUT_STAGES-1];

endmodule

// File: doc/sgd_x_writeback_engine.md
SGD_X_WRITEBACK_ENGINE -- requirements
Module: sgd_x_writeback_engine

Interface
REQ-001 SHALL have parameter ENGINE_NUM, default 8, number of engine FIFOs gathered (1..16).
REQ-002 SHALL have parameter DATA_W, default 512, beat width in bits.
REQ-003 SHALL have parameter BEATS_PER_ENGINE, default 4, consecutive beats read from one engine per turn (power of two, 1..8).
REQ-004 SHALL have parameter DIMS_PER_ROUND, default 256, model dimensions covered by one full round (ENGINE_NUM*BEATS_PER_ENGINE beats).
REQ-005 SHALL have parameter BYTES_PER_DIM, default 4, bytes per dimension in memory.
REQ-006 SHALL have parameter RD_LAT, default 1, FIFO read-data latency in cycles after rd_en (1..4).
REQ-007 SHALL have parameter OUT_STAGES, default 2, output register stages after data capture (1..4).
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 started  in  1  level start from root; run begins on its rising edge.
REQ-011 addr_model  in  64  byte base address of model region.
REQ-012 dimension  in  32  model dimension count.
REQ-013 numEpochs  in  32  number of epochs to write back.
REQ-014 x_to_mem_rd_data  in  ENGINE_NUM x DATA_W  per-engine FIFO read data.
REQ-015 x_to_mem_rd_en  out  ENGINE_NUM  per-engine FIFO read enable, at most one bit high per cycle.
REQ-016 x_to_mem_empty  in  ENGINE_NUM  per-engine FIFO empty.
REQ-017 x_data_send_back_start  out  1  one-cycle write-command pulse.
REQ-018 x_data_send_back_addr  out  64  command byte address, valid with start.
REQ-019 x_data_send_back_length  out  32  command byte length, valid with start.
REQ-020 x_data_out  out  DATA_W  write data beat.
REQ-021 x_data_out_valid  out  1  beat qualifier.
REQ-022 x_data_out_almost_full  in  1  downstream backpressure.
REQ-023 done  out  1  run complete, level.
REQ-024 error  out  1  dimension was zero at start, level.

Function
REQ-025 States SHALL be IDLE, EPOCH_WAIT, DATA, DONE.
REQ-026 IDLE: on started rising edge (started high, previous-cycle started low) SHALL latch addr_model, dimension, numEpochs, compute rounds = ceil(dimension/DIMS_PER_ROUND), length = dimension*BYTES_PER_DIM (low 32 bits), clear counters, go EPOCH_WAIT next cycle; dimension==0 SHALL set error and go DONE.
REQ-027 EPOCH_WAIT: if epoch_cnt==numEpochs go DONE; else when all ENGINE_NUM empty bits are low, pulse start for one cycle with addr = base + epoch_cnt*length (64-bit), go DATA.
REQ-028 DATA: a read SHALL issue in a cycle iff registered almost_full is low and current engine's empty is low; rd_en bit = current engine, registered (rd_en visible one cycle after issue decision).
REQ-029 Counters SHALL advance per issued read: beat 0..BEATS_PER_ENGINE-1, then engine 0..ENGINE_NUM-1, then round 0..rounds-1; all wrap to 0.
REQ-030 On the read issuing last beat of last engine of last round, epoch_cnt SHALL increment and state SHALL return to EPOCH_WAIT.
REQ-031 Read data SHALL be captured RD_LAT cycles after rd_en from the engine tagged in a matching delay pipe, then delayed OUT_STAGES cycles to x_data_out/x_data_out_valid; order preserved, no drop, no duplicate.
REQ-032 Downstream SHALL guarantee almost_full asserts with at least RD_LAT+OUT_STAGES+3 free slots; block relies on this for in-flight beats.
REQ-033 DONE: done high; when started low, return to IDLE and clear done/error.
REQ-034 started falling in EPOCH_WAIT or DATA SHALL NOT abort; run completes.
REQ-035 numEpochs==0 with dimension!=0 SHALL go DONE with no start pulse.
REQ-036 Beats per epoch SHALL equal rounds*ENGINE_NUM*BEATS_PER_ENGINE.

Reset
REQ-037 On rst_n low all outputs SHALL be 0, state IDLE, all counters and delay pipes cleared, asynchronously; rst_n mid-run SHALL abandon the run with no further rd_en or valid after deassertion.

Verification
REQ-038 ENGINE_NUM=8, dimension=512, numEpochs=2, addr_model=0x1000, FIFOs full -> two start pulses, addr 0x1000 and 0x1800, length 2048; 64 beats per epoch in engine order 0,0,0,0,1,...; done high.
REQ-039 dimension=300 -> rounds=2, length=1200, 64 beats per epoch.
REQ-040 almost_full toggled randomly with 8-slot headroom -> output sequence identical to unstalled run, no overflow.
REQ-041 engine 3 empty for 20 cycles mid-epoch -> reads stall at engine 3, no rd_en to other engines, resume in order.
REQ-042 dimension=0 -> error=1, done=1, no start, no rd_en; numEpochs=0 -> done=1, error=0, no start.
REQ-043 rst_n pulsed low during DATA -> all outputs 0 immediately; new started edge -> run restarts at epoch 0, addr_model.
